// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} clk_div_state_t;
  localparam int DIV_W_DEF = 8;
  localparam int DIV_MIN   = 2;
endpackage

// File: rtl/clk_div_counter.sv
// Period counter for the divider: owns the active divisor, the phase count,
// and the registered tick/div_out. The divisor only changes when load is high.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int W       = DIV_W_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_div,
  output logic         tick_nxt,
  output logic         tick,
  output logic         div_out
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         tick_q, div_out_q, div_out_d;

  // tick_q marks cnt_q == div_q-1, so it doubles as the wrap condition.
  always_comb begin
    div_d = load ? load_div : div_q;
    cnt_d = '0;
    if (!clear && run && !tick_q) cnt_d = cnt_q + W'(1);
    tick_nxt  = !clear && (cnt_d == div_d - W'(1));
    div_out_d = !clear && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_q     <= W'(DEF_DIV);
      tick_q    <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_nxt;
      div_out_q <= div_out_d;
    end
  end

  assign tick    = tick_q;
  assign div_out = div_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: FSM, shadow divisor and req/ack handshake.
//   state | meaning
//   IDLE  | stopped, cnt held at 0, divisor loads immediately
//   RUN   | counting periods
//   PEND  | legal divisor in shadow, waiting for the period boundary
//   DRAIN | enable dropped, finishing the current period
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int W       = DIV_W_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cfg_req,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ack,
  output logic         cfg_err,
  output logic         tick,
  output logic         div_out,
  output logic         running
);

  clk_div_state_t state_q, state_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic           ack_q, ack_d, err_q, err_d, run_q, run_d, blk_q, blk_d;
  logic           load, clear, tick_nxt, legal, req_new, rej;
  logic [W-1:0]   load_div;

  assign legal   = cfg_div >= W'(DIV_MIN);
  // blk_q suppresses a request still held after its ack until cfg_req goes low.
  assign req_new = cfg_req && !blk_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    load_div = cfg_div;
    unique case (state_q)
      IDLE: begin
        if (req_new && legal) load = 1'b1;
        if (enable) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (tick && !enable) begin
          state_d = IDLE;
        end else if (req_new && legal) begin
          shadow_d = cfg_div;
          state_d  = PEND;
        end else begin
          state_d = enable ? RUN : DRAIN;
        end
      end
      PEND: begin
        if (tick) begin
          load     = 1'b1;
          load_div = shadow_q;
          state_d  = enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clear = (state_d == IDLE);

  // PEND acks land on the tick cycle; the load happens at the following edge.
  always_comb begin
    rej   = (state_q != PEND) && req_new && !legal;
    ack_d = rej || (state_q == IDLE && req_new && legal) ||
            (state_d == PEND && tick_nxt);
    err_d = rej;
    run_d = !clear;
    blk_d = ack_d || (cfg_req && blk_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= W'(DEF_DIV);
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
      blk_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      run_q    <= run_d;
      blk_q    <= blk_d;
    end
  end

  clk_div_counter #(.W(W), .DEF_DIV(DEF_DIV)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != IDLE),
    .clear    (clear),
    .load     (load),
    .load_div (load_div),
    .tick_nxt (tick_nxt),
    .tick     (tick),
    .div_out  (div_out)
  );

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;
  assign running = run_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected per-cycle outputs are queued with
// the stimulus and compared at the falling edge of the matching cycle.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       rst, enable, cfg_req;
  logic [7:0] cfg_div;
  logic       cfg_ack, cfg_err, tick, div_out, running;

  clk_div_ctrl #(.W(8), .DEF_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_req(cfg_req), .cfg_div(cfg_div),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .tick(tick), .div_out(div_out),
    .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    logic  val;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic obs_bit(input int sel);
    case (sel)
      0:       return tick;
      1:       return div_out;
      2:       return running;
      3:       return cfg_ack;
      default: return cfg_err;
    endcase
  endfunction

  task automatic sb_push(input int c, input string tag, input int sel, input logic v);
    exp_t e;
    int   i;
    e.cyc = c; e.tag = tag; e.sel = sel; e.val = v;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
    sb_q.insert(i, e);
  endtask

  task automatic expect_run(input int org, input int n, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      int ph;
      ph = (c - org) % n;
      sb_push(c, "tick", 0, ph == n - 1);
      sb_push(c, "div_out", 1, ph < n / 2);
      sb_push(c, "running", 2, 1'b1);
    end
  endtask

  task automatic expect_idle(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      sb_push(c, "idle_tick", 0, 1'b0);
      sb_push(c, "idle_div_out", 1, 1'b0);
      sb_push(c, "idle_running", 2, 1'b0);
    end
  endtask

  task automatic expect_ack0(input int from, input int to);
    for (int c = from; c <= to; c++) sb_push(c, "ack_quiet", 3, 1'b0);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      check_eq(mon_e.tag, obs_bit(mon_e.sel), mon_e.val);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until ack is seen, then drops it in the following cycle.
  task automatic req_cfg(input logic [7:0] d);
    int k;
    cfg_div = d;
    cfg_req = 1'b1;
    k = 0;
    @(negedge clk);
    while (!cfg_ack && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (!cfg_ack) check_eq("ack_wait", cfg_ack, 1);
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, org, t_ack, org2, d3, d4, org3, org4, d5, e2, org5, org6, org7, x, org8;
    rst = 1'b0; enable = 1'b0; cfg_req = 1'b0; cfg_div = '0;
    step(2);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_div_out", div_out, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_ack", cfg_ack, 0);
    check_eq("rst_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b1;
    step(2);

    // default divisor 4 after enable
    c0 = cyc; enable = 1'b1; org = c0 + 1;
    sb_push(c0, "run_lat", 2, 1'b0);
    expect_run(org, 4, org, org + 8);
    expect_ack0(c0, org + 8);
    step(10);

    // legal change to 7 mid-period, acked on the next tick
    t_ack = cyc + 2; org2 = t_ack + 1;
    expect_run(org, 4, org + 9, t_ack);
    sb_push(t_ack - 1, "ack_early", 3, 1'b0);
    sb_push(t_ack, "ack_n7", 3, 1'b1);
    sb_push(t_ack, "err_n7", 4, 1'b0);
    expect_run(org2, 7, org2, org2 + 13);
    req_cfg(8'd7);

    // illegal divisors while running
    step(2); d3 = cyc;
    sb_push(d3 + 1, "ack_ill1_run", 3, 1'b1);
    sb_push(d3 + 1, "err_ill1_run", 4, 1'b1);
    req_cfg(8'd1);
    step(1); d4 = cyc;
    sb_push(d4 + 1, "ack_ill0_run", 3, 1'b1);
    sb_push(d4 + 1, "err_ill0_run", 4, 1'b1);
    req_cfg(8'd0);

    // divisor 5, then drain, re-enable, and re-enable during drain
    step(1);
    org3 = org2 + 14;
    sb_push(org2 + 13, "ack_n5", 3, 1'b1);
    sb_push(org2 + 13, "err_n5", 4, 1'b0);
    expect_run(org3, 5, org3, org3 + 4);
    req_cfg(8'd5);
    step(1); enable = 1'b0;
    expect_idle(org3 + 5, org3 + 7);
    step(6);
    enable = 1'b1; org4 = cyc + 1;
    expect_run(org4, 5, org4, org4 + 14);
    expect_idle(org4 + 15, org4 + 25);
    step(2); enable = 1'b0;
    step(1); enable = 1'b1;
    step(9); enable = 1'b0;
    step(6); d5 = cyc;

    // illegal then legal requests in IDLE
    sb_push(d5 + 1, "ack_ill1_idle", 3, 1'b1);
    sb_push(d5 + 1, "err_ill1_idle", 4, 1'b1);
    req_cfg(8'd1);
    step(1);
    sb_push(d5 + 4, "ack_ill0_idle", 3, 1'b1);
    sb_push(d5 + 4, "err_ill0_idle", 4, 1'b1);
    req_cfg(8'd0);
    step(1);
    sb_push(d5 + 7, "ack_n3_idle", 3, 1'b1);
    sb_push(d5 + 7, "err_n3_idle", 4, 1'b0);
    req_cfg(8'd3);
    enable = 1'b1; e2 = cyc; org5 = e2 + 1;
    expect_run(org5, 3, org5, org5 + 5);
    sb_push(org5 + 5, "ack_n255", 3, 1'b1);
    sb_push(org5 + 5, "err_n255", 4, 1'b0);
    step(4);

    // maximum divisor, and a request raised on a tick cycle
    org6 = org5 + 6; org7 = org6 + 510;
    expect_run(org6, 255, org6, org6 + 509);
    sb_push(org6 + 254, "ack_on_tick", 3, 1'b0);
    sb_push(org6 + 255, "ack_after_tick", 3, 1'b0);
    sb_push(org6 + 509, "ack_next_bound", 3, 1'b1);
    sb_push(org6 + 509, "err_next_bound", 4, 1'b0);
    expect_run(org7, 3, org7, org7 + 3);
    req_cfg(8'd255);
    step(254);
    req_cfg(8'd3);

    // reset while a change is pending
    step(3); cfg_div = 8'd6; cfg_req = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; cfg_req = 1'b0; enable = 1'b0;
    #1;
    check_eq("pend_rst_tick", tick, 0);
    check_eq("pend_rst_div_out", div_out, 0);
    check_eq("pend_rst_running", running, 0);
    check_eq("pend_rst_ack", cfg_ack, 0);
    check_eq("pend_rst_err", cfg_err, 0);
    step(2);
    @(negedge clk);
    rst = 1'b1;
    step(1); x = cyc;
    expect_idle(x, x + 3);
    expect_ack0(x, x + 15);
    step(3);
    enable = 1'b1; org8 = cyc + 1;
    expect_run(org8, 4, org8, org8 + 11);
    step(14);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
